mac_tx_arbiter: RTL

Packet-atomic round-robin arbiter sharing one MAC transmit interface between NUM_PORTS switch output queues. Each queue presents a 32-bit word stream with sop/eop/bv framing. The arbiter grants one queue per packet and forwards its words onto the MAC tx_* signals with one cycle of registered latency. It enforces a configurable inter-packet gap and flags framing errors.

---
 rtl/eth_sw_pkg.sv | 17 +
 rtl/mac_tx_arbiter_rr_arbiter.sv | 30 +++
 rtl/mac_tx_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/eth_sw_pkg.sv
// Shared widths and types for the switch egress path.
// No logic: constants and typedefs only.
// Imported by the MAC transmit arbiter and its round-robin picker.
package eth_sw_pkg;

  localparam int WORD_W = 32;
  localparam int BV_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  typedef logic [BV_W-1:0] bv_t;

endpackage

// File: rtl/mac_tx_arbiter_rr_arbiter.sv
// Round-robin winner pick: first requester after i_last, wrapping modulo NUM_PORTS.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  output logic [IDX_W-1:0]     o_win,
  output logic                 o_vld
);

  logic [IDX_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest requester after i_last overwrites the rest.
  always_comb begin
    o_win = '0;
    o_vld = 1'b0;
    w_idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_last) + k) % NUM_PORTS);
      if (i_req[w_idx]) begin
        o_win = w_idx;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-atomic round-robin share of one MAC tx interface among NUM_PORTS queues.
// Latency: request in IDLE at n -> in_ready at n+1 -> tx_sop at n+2; tx_* is one register behind the accepted word.
// Backpressure: in_ready is one-hot to the granted queue only; bubbles pass through as tx_valid=0.
module mac_tx_arbiter
  import eth_sw_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int IFG_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_enable,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS-1:0]          in_sop,
  input  logic [NUM_PORTS-1:0]          in_eop,
  input  logic [BV_W*NUM_PORTS-1:0]     in_bv,
  input  logic [WORD_W*NUM_PORTS-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic                          tx_valid,
  output logic                          tx_sop,
  output logic                          tx_eop,
  output logic [BV_W-1:0]               tx_bv,
  output logic [WORD_W-1:0]             tx_data,
  output logic                          busy,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          err_sop,
  output logic [31:0]                   tx_pkt_cnt
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);
  localparam logic [3:0] GAP_LAST = 4'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_grant;
  logic [3:0]         r_gap_cnt;
  logic               r_first;
  logic               r_tx_valid;
  logic               r_tx_sop;
  logic               r_tx_eop;
  bv_t                r_tx_bv;
  logic [WORD_W-1:0]  r_tx_data;
  logic               r_err_sop;
  logic [31:0]        r_pkt_cnt;

  logic [NUM_PORTS-1:0] w_req;
  logic [IDX_W-1:0]     w_win;
  logic                 w_win_vld;
  logic                 w_open;
  logic                 w_xfer;
  logic [NUM_PORTS-1:0] w_ready;
  logic                 w_sel_vld;
  logic                 w_sel_sop;
  logic                 w_sel_eop;
  bv_t                  w_sel_bv;
  logic [WORD_W-1:0]    w_sel_data;

  assign w_req = in_valid & in_sop;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_vld  (w_win_vld)
  );

  // The cycle that shows tx_eop is a drain cycle: the grant is still held but nothing more is accepted.
  assign w_open = (r_state == XFER) && !r_tx_eop;
  assign w_xfer = w_open && w_sel_vld;

  // Mux the granted queue onto the selection wires and raise its in_ready.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_sop  = 1'b0;
    w_sel_eop  = 1'b0;
    w_sel_bv   = '0;
    w_sel_data = '0;
    w_ready    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_grant == IDX_W'(p)) begin
        w_sel_vld  = in_valid[p];
        w_sel_sop  = in_sop[p];
        w_sel_eop  = in_eop[p];
        w_sel_bv   = in_bv[BV_W*p +: BV_W];
        w_sel_data = in_data[WORD_W*p +: WORD_W];
        w_ready[p] = w_open;
      end
    end
  end

  // Arbitration FSM plus the registered tx word, error pulse and packet counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= LAST_RST;
      r_grant    <= '0;
      r_gap_cnt  <= '0;
      r_first    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_tx_bv    <= '0;
      r_tx_data  <= '0;
      r_err_sop  <= 1'b0;
      r_pkt_cnt  <= '0;
    end else begin
      r_tx_valid <= w_xfer;
      // sop is only honoured on the first word of a grant; a misplaced or missing sop is flagged.
      r_tx_sop   <= w_xfer && w_sel_sop && r_first;
      r_tx_eop   <= w_xfer && w_sel_eop;
      r_err_sop  <= w_xfer && (w_sel_sop != r_first);
      if (w_xfer) begin
        r_tx_bv   <= w_sel_bv;
        r_tx_data <= w_sel_data;
        r_first   <= 1'b0;
      end
      if (w_xfer && w_sel_eop) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      case (r_state)
        IDLE: begin
          if (cfg_enable && w_win_vld) begin
            r_grant <= w_win;
            r_last  <= w_win;
            r_first <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (r_tx_eop) begin
            r_gap_cnt <= '0;
            r_state   <= (IFG_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = w_ready;
  assign tx_valid   = r_tx_valid;
  assign tx_sop     = r_tx_sop;
  assign tx_eop     = r_tx_eop;
  assign tx_bv      = r_tx_bv;
  assign tx_data    = r_tx_data;
  assign busy       = (r_state != IDLE);
  assign grant_id   = r_grant;
  assign err_sop    = r_err_sop;
  assign tx_pkt_cnt = r_pkt_cnt;

endmodule
